axil_ram_responder: RTL

- AXI4-Lite slave (responder) fronting a single-port-per-channel word RAM; the memory-side end of the HLS-generated AXI-lite read/write initiators.
- Services one outstanding read and one outstanding write independently. Provides a debug side port for testbench preload and inspection.
- Sits directly on the initiator's s_axil_* / debug_* bundle; port names are the initiator's names seen from the other side.

---
 rtl/axil_ram_responder_if.sv | 49 ++++
 rtl/axil_ram_responder.sv | 131 +++++++++++++
 2 files changed

// File: rtl/axil_ram_responder_if.sv
// axil_ram_responder_if: AXI4-Lite slave bundle plus debug preload/inspection port
interface axil_ram_responder_if #(
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] s_axil_araddr;
    logic [2:0]            s_axil_arprot;
    logic                  s_axil_arvalid;
    logic                  s_axil_arready;
    logic [31:0]           s_axil_rdata;
    logic [1:0]            s_axil_rresp;
    logic                  s_axil_rvalid;
    logic                  s_axil_rready;
    logic [ADDR_WIDTH-1:0] s_axil_awaddr;
    logic [2:0]            s_axil_awprot;
    logic                  s_axil_awvalid;
    logic                  s_axil_awready;
    logic [31:0]           s_axil_wdata;
    logic [3:0]            s_axil_wstrb;
    logic                  s_axil_wvalid;
    logic                  s_axil_wready;
    logic [1:0]            s_axil_bresp;
    logic                  s_axil_bvalid;
    logic                  s_axil_bready;
    logic [ADDR_WIDTH-1:0] debug_addr;
    logic [31:0]           debug_data;
    logic [ADDR_WIDTH-1:0] debug_wr_addr;
    logic [31:0]           debug_wr_data;
    logic                  debug_wr_en;

    modport slave (
        input  s_axil_araddr, s_axil_arprot, s_axil_arvalid, s_axil_rready,
        input  s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
        input  s_axil_wdata, s_axil_wstrb, s_axil_wvalid, s_axil_bready,
        input  debug_addr, debug_wr_addr, debug_wr_data, debug_wr_en,
        output s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
        output s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
        output debug_data
    );

    modport master (
        output s_axil_araddr, s_axil_arprot, s_axil_arvalid, s_axil_rready,
        output s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
        output s_axil_wdata, s_axil_wstrb, s_axil_wvalid, s_axil_bready,
        output debug_addr, debug_wr_addr, debug_wr_data, debug_wr_en,
        input  s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
        input  s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
        input  debug_data
    );
endinterface

// File: rtl/axil_ram_responder.sv
// axil_ram_responder: AXI4-Lite word RAM with independent read/write paths and a debug port
module axil_ram_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input logic clk,
    input logic rst,
    axil_ram_responder_if.slave s
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    r_state_t r_rstate, w_rnext;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata, r_wdata, r_debug_data;
    logic [1:0]            r_rresp, r_bresp;
    logic                  r_bvalid, r_aw_held, r_w_held;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [3:0]            r_wstrb;

    logic                  w_arready, w_awready, w_wready;
    logic                  w_ar_hs, w_aw_hs, w_w_hs, w_commit;
    logic                  w_ar_oor, w_cm_oor;
    logic [ADDR_WIDTH-1:0] w_cm_addr;
    logic [DATA_WIDTH-1:0] w_cm_data;
    logic [3:0]            w_cm_strb;
    logic [DEPTH_LOG2-1:0] w_ar_idx, w_cm_idx, w_dbg_idx, w_dbg_wr_idx;
    logic                  w_unused;

    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
        return |(a >> (DEPTH_LOG2 + 2));
    endfunction

    // Read FSM next state and AR acceptance; ready depends only on state and reset
    always_comb begin
        w_arready = !rst && (r_rstate == R_IDLE);
        w_ar_hs   = s.s_axil_arvalid && w_arready;
        w_ar_idx  = s.s_axil_araddr[DEPTH_LOG2+1:2];
        w_ar_oor  = out_of_range(s.s_axil_araddr);
        w_rnext   = (r_rstate == R_IDLE) ? (w_ar_hs ? R_RESP : R_IDLE)
                                         : (s.s_axil_rready ? R_IDLE : R_RESP);
    end

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (rst) r_rstate <= R_IDLE;
        else     r_rstate <= w_rnext;
    end

    // Read data captured at the AR handshake and held until the R handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_rresp <= 2'b00;
        end else if (w_ar_hs) begin
            r_rdata <= w_ar_oor ? '0 : r_mem[w_ar_idx];
            r_rresp <= w_ar_oor ? 2'b10 : 2'b00;
        end
    end

    // Write path: select held or live AW/W values and detect the commit cycle
    always_comb begin
        w_awready    = !rst && !r_aw_held && !r_bvalid;
        w_wready     = !rst && !r_w_held && !r_bvalid;
        w_aw_hs      = s.s_axil_awvalid && w_awready;
        w_w_hs       = s.s_axil_wvalid && w_wready;
        w_commit     = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
        w_cm_addr    = r_aw_held ? r_awaddr : s.s_axil_awaddr;
        w_cm_data    = r_w_held ? r_wdata : s.s_axil_wdata;
        w_cm_strb    = r_w_held ? r_wstrb : s.s_axil_wstrb;
        w_cm_idx     = w_cm_addr[DEPTH_LOG2+1:2];
        w_cm_oor     = out_of_range(w_cm_addr);
        w_dbg_idx    = s.debug_addr[DEPTH_LOG2-1:0];
        w_dbg_wr_idx = s.debug_wr_addr[DEPTH_LOG2-1:0];
    end

    // AW/W holding registers and B response; readies stay low while B is pending
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
        end else if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_cm_oor ? 2'b10 : 2'b00;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= s.s_axil_awaddr;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s.s_axil_wdata;
                r_wstrb  <= s.s_axil_wstrb;
            end
            if (r_bvalid && s.s_axil_bready) r_bvalid <= 1'b0;
        end
    end

    // RAM writes: byte-masked AXI commit, then the debug write so it wins on a clash
    always_ff @(posedge clk) begin
        if (w_commit && !w_cm_oor)
            for (int i = 0; i < 4; i++)
                if (w_cm_strb[i]) r_mem[w_cm_idx][8*i +: 8] <= w_cm_data[8*i +: 8];
        if (s.debug_wr_en) r_mem[w_dbg_wr_idx] <= s.debug_wr_data;
    end

    // Debug read port, refreshed every cycle
    always_ff @(posedge clk) begin
        if (rst) r_debug_data <= '0;
        else     r_debug_data <= r_mem[w_dbg_idx];
    end

    assign w_unused = &{1'b0, s.s_axil_arprot, s.s_axil_awprot, s.s_axil_araddr[1:0], w_cm_addr[1:0],
                        s.debug_addr[ADDR_WIDTH-1:DEPTH_LOG2], s.debug_wr_addr[ADDR_WIDTH-1:DEPTH_LOG2]};

    assign s.s_axil_arready = w_arready;
    assign s.s_axil_rvalid  = (r_rstate == R_RESP);
    assign s.s_axil_rdata   = r_rdata;
    assign s.s_axil_rresp   = r_rresp;
    assign s.s_axil_awready = w_awready;
    assign s.s_axil_wready  = w_wready;
    assign s.s_axil_bvalid  = r_bvalid;
    assign s.s_axil_bresp   = r_bresp;
    assign s.debug_data     = r_debug_data;
endmodule
